button_event_counter: RTL and testbench

- Input-side counterpart of the free-running LED counter: reads two pushbuttons and drives the same 8 LEDs and D13.
- Each button is synchronised and debounced, then edge-detected; SW1 presses increment and SW2 presses decrement an 8-bit value shown on LED7..LED0.
- Top-level demo block for the icezum board, 12 MHz CLK.

---
 rtl/button_event_counter.sv | 118 +++++++++++
 tb/tb_button_event_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_counter.sv
// button_event_counter: two debounced pushbuttons increment/decrement an 8-bit LED count.
// D13 shows when either button is held in its debounced-pressed state.
module debounce_fsm #(
    parameter int STABLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic tick,
    output logic evt,
    output logic held
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    state_t state, state_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic evt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            evt   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            evt   <= evt_next;
        end
    end

    // A level mismatch aborts the wait immediately; only agreement is tick-gated.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        evt_next   = 1'b0;
        cnt_inc    = cnt + 4'd1;
        case (state)
            IDLE: if (s) begin
                state_next = PRESS_WAIT;
                cnt_next   = 4'd0;
            end
            PRESS_WAIT: if (!s) begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end else if (tick) begin
                cnt_next = cnt_inc;
                if (cnt_inc == 4'(STABLE)) begin
                    state_next = PRESSED;
                    cnt_next   = 4'd0;
                    evt_next   = 1'b1;
                end
            end
            PRESSED: if (!s) begin
                state_next = RELEASE_WAIT;
                cnt_next   = 4'd0;
            end
            RELEASE_WAIT: if (s) begin
                state_next = PRESSED;
                cnt_next   = 4'd0;
            end else if (tick) begin
                cnt_next = cnt_inc;
                if (cnt_inc == 4'(STABLE)) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign held = (state == PRESSED) || (state == RELEASE_WAIT);
endmodule

module button_event_counter #(
    parameter int N      = 16,
    parameter int STABLE = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       SW1,
    input  logic       SW2,
    output logic [7:0] LEDS,
    output logic       D13
);
    logic [N-1:0] presc;
    logic         tick;
    logic [1:0]   meta, sync, evt, held;
    logic [7:0]   count;

    assign tick = &presc;
    assign LEDS = count;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            presc <= '0;
            meta  <= 2'b00;
            sync  <= 2'b00;
            count <= 8'h00;
            D13   <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            meta  <= {SW2, SW1};
            sync  <= meta;
            count <= (evt == 2'b01) ? count + 8'd1 : (evt == 2'b10) ? count - 8'd1 : count;
            D13   <= |held;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_btn
        debounce_fsm #(.STABLE(STABLE)) u_fsm (
            .clk  (CLK),
            .rst_n(RSTN),
            .s    (sync[i]),
            .tick (tick),
            .evt  (evt[i]),
            .held (held[i])
        );
    end
endmodule

// File: tb/tb_button_event_counter.sv
// tb_button_event_counter: directed and random button traffic checked against an
// accepted-level debounce model (level must persist for STABLE ticks to be taken).
module tb_button_event_counter;
    localparam int N = 2;
    localparam int STABLE = 2;
    localparam int PERIOD = 1 << N;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       SW1 = 1'b0;
    logic       SW2 = 1'b0;
    logic [7:0] LEDS;
    logic       D13;

    int checks = 0;
    int failures = 0;

    int m_presc, m_count;
    bit m_d13;
    bit m_meta[2], m_s[2], m_deb[2], m_started[2], m_evt[2];
    int m_ticks[2];

    button_event_counter #(.N(N), .STABLE(STABLE)) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .SW1 (SW1),
        .SW2 (SW2),
        .LEDS(LEDS),
        .D13 (D13)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_count = 0;
        m_d13 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_meta[b] = 1'b0;
            m_s[b] = 1'b0;
            m_deb[b] = 1'b0;
            m_started[b] = 1'b0;
            m_evt[b] = 1'b0;
            m_ticks[b] = 0;
        end
    endtask

    // Applies one rising edge: every update uses the values seen before the edge.
    task automatic model_edge();
        bit tick;
        bit pins[2];
        tick = (m_presc == PERIOD - 1);
        pins[0] = SW1;
        pins[1] = SW2;
        if (m_evt[0] && !m_evt[1]) m_count = (m_count + 1) % 256;
        else if (!m_evt[0] && m_evt[1]) m_count = (m_count + 255) % 256;
        m_d13 = m_deb[0] | m_deb[1];
        for (int b = 0; b < 2; b++) begin
            m_evt[b] = 1'b0;
            if (m_s[b] != m_deb[b]) begin
                if (!m_started[b]) begin
                    m_started[b] = 1'b1;
                    m_ticks[b] = 0;
                end else if (tick) begin
                    m_ticks[b]++;
                    if (m_ticks[b] == STABLE) begin
                        m_deb[b] = m_s[b];
                        m_started[b] = 1'b0;
                        m_evt[b] = m_s[b];
                    end
                end
            end else begin
                m_started[b] = 1'b0;
            end
            m_s[b] = m_meta[b];
            m_meta[b] = pins[b];
        end
        m_presc = (m_presc + 1) % PERIOD;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_edge();
            #1;
            chk("leds", 32'(LEDS), 32'(m_count));
            chk("d13", 32'(D13), 32'(m_d13));
            chk("tick", 32'(dut.tick), 32'(m_presc == PERIOD - 1));
        end
    endtask

    task automatic pulse_reset();
        #2;
        RSTN = 1'b0;
        #1;
        chk("rst_async_leds", 32'(LEDS), 32'h00);
        chk("rst_async_d13", 32'(D13), 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    task automatic press(input int b);
        if (b == 0) SW1 = 1'b1; else SW2 = 1'b1;
        step(16);
        if (b == 0) SW1 = 1'b0; else SW2 = 1'b0;
        step(16);
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        chk("reset_leds", 32'(LEDS), 32'h00);
        chk("reset_d13", 32'(D13), 32'h0);
        RSTN = 1'b1;
        step(100);
        chk("idle_leds", 32'(LEDS), 32'h00);

        SW1 = 1'b1;
        step(13);
        chk("single_inc_latency", 32'(LEDS), 32'h01);
        step(27);
        SW1 = 1'b0;
        step(20);
        chk("single_inc_once", 32'(LEDS), 32'h01);
        chk("single_release_d13", 32'(D13), 32'h0);

        pulse_reset();
        repeat (5) begin
            SW1 = 1'b1;
            step(3);
            SW1 = 1'b0;
            step(3);
        end
        chk("bounce_no_change", 32'(LEDS), 32'h00);
        SW1 = 1'b1;
        step(16);
        chk("bounce_settled", 32'(LEDS), 32'h01);
        SW1 = 1'b0;
        step(16);

        pulse_reset();
        press(1);
        chk("wrap_down", 32'(LEDS), 32'hFF);
        for (int i = 0; i < 256; i++) begin
            press(0);
            if (i == 0) chk("wrap_up", 32'(LEDS), 32'h00);
        end
        chk("wrap_full_circle", 32'(LEDS), 32'hFF);

        pulse_reset();
        SW1 = 1'b1;
        SW2 = 1'b1;
        step(16);
        chk("both_cancel", 32'(LEDS), 32'h00);
        SW2 = 1'b0;
        step(16);
        SW2 = 1'b1;
        step(16);
        chk("repress_dec", 32'(LEDS), 32'hFF);
        SW1 = 1'b0;
        SW2 = 1'b0;
        step(16);

        pulse_reset();
        SW1 = 1'b1;
        step(5);
        pulse_reset();
        step(16);
        chk("reset_press_wait", 32'(LEDS), 32'h01);
        SW1 = 1'b0;
        step(16);
        repeat (4) press(0);
        chk("count_five", 32'(LEDS), 32'h05);
        SW1 = 1'b1;
        step(4);
        pulse_reset();
        step(16);
        chk("reset_held_once", 32'(LEDS), 32'h01);
        SW1 = 1'b0;
        step(16);

        repeat (80) begin
            SW1 = 1'($urandom_range(0, 1));
            SW2 = 1'($urandom_range(0, 1));
            step(int'($urandom_range(1, 24)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
